// File: rtl/mac_accumulator_4_bits_pkg.sv
// Shared definitions for the accumulate stage that follows the 4x4 array multiplier.
// Contents: the controller state encoding and the default datapath widths.
// The package has no ports.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int ACC_W_DEF = 16;  // accumulator/result width, legal 9..32
    localparam int CNT_W_DEF = 4;   // term-count width, max terms = 2**CNT_W-1

endpackage

// File: rtl/mac_accumulator_4_bits_if.sv
// Job/product/result bundle between the requester (master) and the accumulate stage (slave).
// Signals:
//   start, len         job start pulse and term count (master -> slave)
//   p_in, p_valid      product from the multiplier with its valid (master -> slave)
//   p_ready            stage can accept p_in (slave -> master)
//   acc_out, done, ovf result, result-final flag, sticky overflow (slave -> master)
//   res_ack            result consumed (master -> slave)
interface mac_accumulator_4_bits_if
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic [CNT_W-1:0] len;
    logic [7:0]       p_in;
    logic             p_valid;
    logic             p_ready;
    logic [ACC_W-1:0] acc_out;
    logic             done;
    logic             res_ack;
    logic             ovf;

    modport master (
        output start, len, p_in, p_valid, res_ack,
        input  p_ready, acc_out, done, ovf
    );

    modport slave (
        input  start, len, p_in, p_valid, res_ack,
        output p_ready, acc_out, done, ovf
    );

endinterface

// File: rtl/mac_accumulator_4_bits.sv
// Sequential accumulate stage: sums a programmed number of 8-bit unsigned products taken
// over a valid/ready handshake, then holds the sum with done until acknowledged.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   mac_accumulator_4_bits_if.slave (start/len, p_in/p_valid/p_ready,
//         acc_out/done/ovf, res_ack)
// Configuration:
//   MAC_ACC_SATURATE_EN defined   : on carry-out acc_out clamps to all-ones for the rest of the job
//   MAC_ACC_SATURATE_EN undefined : acc_out wraps modulo 2**ACC_W
//   ovf is set on carry-out in both builds.
//
// state | meaning
// IDLE  | no job; waiting for start
// ACCUM | accepting products until the programmed count is reached
// DONE  | acc_out/ovf final and held; waiting for res_ack or a new start
module mac_accumulator_4_bits
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic                    clk,
    input logic                    rst,
    mac_accumulator_4_bits_if.slave bus
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic             ovf_q,   ovf_d;

    logic             job_start;
    logic             xfer;
    logic [ACC_W:0]   sum;

    // start is honoured from IDLE and DONE alike; in DONE it doubles as the acknowledge.
    assign job_start = bus.start && (state_q == IDLE || state_q == DONE);
    assign xfer      = bus.p_valid && (state_q == ACCUM);
    assign sum       = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, bus.p_in};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (job_start) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = bus.len;
            state_d = (bus.len != '0) ? ACCUM : DONE;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (xfer) begin
`ifdef MAC_ACC_SATURATE_EN
                        // Once clamped, any further non-zero product carries again and
                        // re-clamps, so the all-ones value holds for the rest of the job.
                        acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                        ovf_d = ovf_q | sum[ACC_W];
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // done is a registered copy of "next state is DONE".
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.p_ready = (state_q == ACCUM);
    assign bus.acc_out = acc_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;

endmodule
